// File: rtl/btn_pkg.sv
// Shared definitions for the button event classifier: state encodings and
// the helper that sizes the gesture timer so it can hold the longest timeout.
package btn_pkg;

  typedef logic [2:0] btn_state_t;

  localparam btn_state_t IDLE    = 3'd0;
  localparam btn_state_t PRESSED = 3'd1;
  localparam btn_state_t LONG    = 3'd2;
  localparam btn_state_t WAIT2   = 3'd3;
  localparam btn_state_t DHELD   = 3'd4;

  // Width needed to count up to the largest of the three timeouts.
  function automatic int btn_timer_width(input int long_ms, input int dbl_ms, input int rpt_ms);
    int m;
    m = long_ms;
    if (dbl_ms > m) m = dbl_ms;
    if (rpt_ms > m) m = rpt_ms;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_tick_gen.sv
// Free-running timebase prescaler: counts 0..TICK_DIV-1 and raises `tick`
// while the count sits at its last value. Shared by UI blocks that need a
// coarse time reference.
module btn_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  // Prescaler counter, wraps after the last value of each period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/btn_event_fsm.sv
// Button gesture classifier. Turns the debounced level `db` into one-cycle
// event pulses (press, release, short, long, double) for the menu controller.
// Optional auto-repeat while long-held is enabled by defining BTN_REPEAT_EN;
// without it rpt_p is tied low and no repeat logic exists.
module btn_event_fsm
  import btn_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int LONG_MS   = 1000,
  parameter int DBL_MS    = 250,
  parameter int REPEAT_MS = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic db,
  output logic press_p,
  output logic release_p,
  output logic short_p,
  output logic long_p,
  output logic dbl_p,
  output logic rpt_p,
  output logic busy
);

  localparam int TW = btn_timer_width(LONG_MS, DBL_MS, REPEAT_MS);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_MS - 1);
  localparam logic [TW-1:0] DBL_LAST  = TW'(DBL_MS - 1);
  localparam logic [TW-1:0] TMAX      = '1;

  logic       w_tick;
  logic       r_db_q;
  btn_state_t r_state;
  btn_state_t w_state_nxt;
  logic [TW-1:0] r_timer;

  logic w_long_hit;
  logic w_dbl_timeout;
  logic w_rpt_restart;

  logic w_short_nxt;
  logic w_long_nxt;
  logic w_dbl_nxt;

  logic r_press_p;
  logic r_release_p;
  logic r_short_p;
  logic r_long_p;
  logic r_dbl_p;
  logic r_busy;

  btn_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick)
  );

  // Timeout conditions fire on the tick that completes the programmed count.
  assign w_long_hit    = w_tick & (r_timer == LONG_LAST);
  assign w_dbl_timeout = w_tick & (r_timer == DBL_LAST);

`ifdef BTN_REPEAT_EN
  localparam logic [TW-1:0] RPT_LAST = TW'(REPEAT_MS - 1);
  logic r_rpt_p;

  assign w_rpt_restart = (r_state == LONG) & db & w_tick & (r_timer == RPT_LAST);

  // Repeat pulse register; the same condition restarts the timer for the next period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rpt_p <= 1'b0;
    end else begin
      r_rpt_p <= w_rpt_restart;
    end
  end

  assign rpt_p = r_rpt_p;
`else
  assign w_rpt_restart = 1'b0;
  assign rpt_p         = 1'b0;
`endif

  // Edge detector on db: independent of the gesture state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_q      <= 1'b0;
      r_press_p   <= 1'b0;
      r_release_p <= 1'b0;
    end else begin
      r_db_q      <= db;
      r_press_p   <= db & ~r_db_q;
      r_release_p <= ~db & r_db_q;
    end
  end

  // State register plus the tick timer, which restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || w_rpt_restart) begin
        r_timer <= '0;
      end else if (w_tick && (r_timer != TMAX)) begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  // Next-state logic; releases and presses take priority over coinciding timeouts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (db) w_state_nxt = PRESSED;
      end
      PRESSED: begin
        if (!db)             w_state_nxt = WAIT2;
        else if (w_long_hit) w_state_nxt = LONG;
      end
      LONG: begin
        if (!db) w_state_nxt = IDLE;
      end
      WAIT2: begin
        if (db)                 w_state_nxt = DHELD;
        else if (w_dbl_timeout) w_state_nxt = IDLE;
      end
      DHELD: begin
        if (!db) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Gesture pulse decode for the transitions taken this cycle.
  always_comb begin
    w_short_nxt = 1'b0;
    w_long_nxt  = 1'b0;
    w_dbl_nxt   = 1'b0;
    case (r_state)
      PRESSED: begin
        if (db && w_long_hit) w_long_nxt = 1'b1;
      end
      WAIT2: begin
        if (db)                 w_dbl_nxt   = 1'b1;
        else if (w_dbl_timeout) w_short_nxt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Output registers so every pulse is a clean single cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_short_p <= 1'b0;
      r_long_p  <= 1'b0;
      r_dbl_p   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_short_p <= w_short_nxt;
      r_long_p  <= w_long_nxt;
      r_dbl_p   <= w_dbl_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign press_p   = r_press_p;
  assign release_p = r_release_p;
  assign short_p   = r_short_p;
  assign long_p    = r_long_p;
  assign dbl_p     = r_dbl_p;
  assign busy      = r_busy;

endmodule
